// File: rtl/ps2_keypad_entry.sv
// ---------------------------------------------------------------------------
// ps2_keypad_entry
//
// Turns the level-style key code from the PS/2 keyboard stage into single
// keypad events (make / break / make), collects a four-digit BCD HH:MM entry
// and hands it to the alarm-clock core with one-cycle load strobes:
//   '-' loads the current time, '*' loads the alarm time.
// A partial entry or a half-finished key sequence is dropped after
// TIMEOUT_CYCLES idle clocks.
//
// Ports
//   ck            : system clock, everything on posedge
//   reset         : synchronous, active-high
//   ps2_key_code  : 8-bit key code level (asynchronous to ck)
//   key_valid     : 1-cycle pulse, a full keypress was decoded
//   key_value     : decoded key (0-9, 4'hA = '-', 4'hB = '*')
//   digits_bcd    : entry buffer {H1,H0,M1,M0}, newest digit in [3:0]
//   digit_count   : number of digits held, 0..4
//   load_time     : 1-cycle pulse, time_bcd holds a new current time
//   load_alarm    : 1-cycle pulse, time_bcd holds a new alarm time
//   time_bcd      : entry captured by the last accepted command
//   entry_error   : 1-cycle pulse, command rejected
//   entry_timeout : 1-cycle pulse, entry discarded by the idle timeout
// ---------------------------------------------------------------------------
module ps2_keypad_entry #(
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic        ck,
  input  logic        reset,
  input  logic [7:0]  ps2_key_code,
  output logic        key_valid,
  output logic [3:0]  key_value,
  output logic [15:0] digits_bcd,
  output logic [2:0]  digit_count,
  output logic        load_time,
  output logic        load_alarm,
  output logic [15:0] time_bcd,
  output logic        entry_error,
  output logic        entry_timeout
);

  // Keypad scan codes (PS/2 set 2) and the release prefix
  localparam logic [7:0] KP_0            = 8'h70;
  localparam logic [7:0] KP_1            = 8'h69;
  localparam logic [7:0] KP_2            = 8'h72;
  localparam logic [7:0] KP_3            = 8'h7A;
  localparam logic [7:0] KP_4            = 8'h6B;
  localparam logic [7:0] KP_5            = 8'h73;
  localparam logic [7:0] KP_6            = 8'h74;
  localparam logic [7:0] KP_7            = 8'h6C;
  localparam logic [7:0] KP_8            = 8'h75;
  localparam logic [7:0] KP_9            = 8'h7D;
  localparam logic [7:0] KP_MINUS        = 8'h7B;
  localparam logic [7:0] KP_STAR         = 8'h7C;
  localparam logic [7:0] KP_KEY_RELEASED = 8'hF0;

  localparam logic [31:0] LAST_IDLE = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAKE  = 2'd1,
    BREAK = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [7:0]  r_codeQ;
  logic [7:0]  r_prevQ;
  logic [7:0]  r_keyReg;
  logic [7:0]  w_keyNext;
  logic [31:0] r_idleCnt;
  logic        w_newCode;
  logic        w_codeValid;
  logic [3:0]  w_keyVal;
  logic        w_emit;
  logic        w_active;
  logic        w_timeout;
  logic        w_nibblesOk;
  logic        w_entryOk;

  function automatic logic isKey(input logic [7:0] code);
    case (code)
      KP_0, KP_1, KP_2, KP_3, KP_4, KP_5, KP_6, KP_7, KP_8, KP_9,
      KP_MINUS, KP_STAR: isKey = 1'b1;
      default:           isKey = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] keyValue(input logic [7:0] code);
    case (code)
      KP_0:     keyValue = 4'd0;
      KP_1:     keyValue = 4'd1;
      KP_2:     keyValue = 4'd2;
      KP_3:     keyValue = 4'd3;
      KP_4:     keyValue = 4'd4;
      KP_5:     keyValue = 4'd5;
      KP_6:     keyValue = 4'd6;
      KP_7:     keyValue = 4'd7;
      KP_8:     keyValue = 4'd8;
      KP_9:     keyValue = 4'd9;
      KP_MINUS: keyValue = 4'hA;
      default:  keyValue = 4'hB;
    endcase
  endfunction

  // Two-stage capture of the code level; a held level gives one change event
  always_ff @(posedge ck) begin
    if (reset) begin
      r_codeQ <= 8'h00;
      r_prevQ <= 8'h00;
    end else begin
      r_codeQ <= ps2_key_code;
      r_prevQ <= r_codeQ;
    end
  end

  assign w_newCode   = (r_codeQ != r_prevQ);
  assign w_codeValid = isKey(r_codeQ);
  assign w_keyVal    = keyValue(r_keyReg);
  assign w_active    = (digit_count != 3'd0) || (r_state != IDLE);
  // A fresh code change on the expiry edge keeps the entry alive
  assign w_timeout   = !w_newCode && w_active && (r_idleCnt == LAST_IDLE);

  // BCD comparison works directly because every nibble is a decimal digit
  assign w_nibblesOk = (digits_bcd[15:12] <= 4'd9) && (digits_bcd[11:8] <= 4'd9) &&
                       (digits_bcd[7:4]   <= 4'd9) && (digits_bcd[3:0]  <= 4'd9);
  assign w_entryOk   = (digit_count == 3'd4) && w_nibblesOk &&
                       (digits_bcd[15:8] <= 8'h23) && (digits_bcd[7:0] <= 8'h59);

  // Key-sequence state register and the key currently being pressed
  always_ff @(posedge ck) begin
    if (reset) begin
      r_state  <= IDLE;
      r_keyReg <= 8'h00;
    end else begin
      r_state  <= w_stateNext;
      r_keyReg <= w_keyNext;
    end
  end

  // Make/break/make decoding; a different key before the final make replaces
  // the pending press (rollover), so only the latest key can complete
  always_comb begin
    w_stateNext = r_state;
    w_keyNext   = r_keyReg;
    w_emit      = 1'b0;
    if (w_newCode) begin
      case (r_state)
        IDLE: begin
          if (w_codeValid) begin
            w_stateNext = MAKE;
            w_keyNext   = r_codeQ;
          end
        end
        MAKE: begin
          if (r_codeQ == KP_KEY_RELEASED) begin
            w_stateNext = BREAK;
          end else if (w_codeValid && (r_codeQ != r_keyReg)) begin
            w_keyNext = r_codeQ;
          end
        end
        BREAK: begin
          if (r_codeQ == r_keyReg) begin
            w_emit      = 1'b1;
            w_stateNext = IDLE;
          end else if (w_codeValid) begin
            w_stateNext = MAKE;
            w_keyNext   = r_codeQ;
          end
        end
        default: w_stateNext = IDLE;
      endcase
    end else if (w_timeout) begin
      w_stateNext = IDLE;
    end
  end

  // Idle counter only runs while something is pending
  always_ff @(posedge ck) begin
    if (reset) begin
      r_idleCnt <= 32'd0;
    end else if (w_newCode || w_timeout || !w_active) begin
      r_idleCnt <= 32'd0;
    end else begin
      r_idleCnt <= r_idleCnt + 32'd1;
    end
  end

  // Entry buffer, command validation and the output strobes
  always_ff @(posedge ck) begin
    if (reset) begin
      key_valid     <= 1'b0;
      key_value     <= 4'd0;
      digits_bcd    <= 16'h0000;
      digit_count   <= 3'd0;
      load_time     <= 1'b0;
      load_alarm    <= 1'b0;
      time_bcd      <= 16'h0000;
      entry_error   <= 1'b0;
      entry_timeout <= 1'b0;
    end else begin
      key_valid     <= 1'b0;
      load_time     <= 1'b0;
      load_alarm    <= 1'b0;
      entry_error   <= 1'b0;
      entry_timeout <= 1'b0;
      if (w_emit) begin
        key_valid <= 1'b1;
        key_value <= w_keyVal;
        if (w_keyVal <= 4'd9) begin
          // Extra digits keep shifting so the buffer holds the last four
          digits_bcd <= {digits_bcd[11:0], w_keyVal};
          if (digit_count != 3'd4) begin
            digit_count <= digit_count + 3'd1;
          end
        end else begin
          if (w_entryOk) begin
            time_bcd <= digits_bcd;
            if (w_keyVal == 4'hA) begin
              load_time <= 1'b1;
            end else begin
              load_alarm <= 1'b1;
            end
          end else begin
            entry_error <= 1'b1;
          end
          digits_bcd  <= 16'h0000;
          digit_count <= 3'd0;
        end
      end else if (w_timeout) begin
        digits_bcd    <= 16'h0000;
        digit_count   <= 3'd0;
        entry_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ps2_keypad_entry.md
Name: ps2_keypad_entry

Overview:
- Sits directly downstream of the PS2 keyboard stage and consumes its 8-bit `ps2_key_code` level.
- Decodes make/break/make sequences into single keypad events.
- Accumulates a 4-digit BCD HH:MM entry and issues one-cycle load strobes to the alarm-clock core: '-' loads the current time, '*' loads the alarm time.
- Abandons a partial entry after an idle timeout.

Parameters:
TIMEOUT_CYCLES, 5000, idle ck cycles before a partial entry or pending key sequence is discarded (must be >= 2)

Ports:
ck  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high
ps2_key_code  input  8  key code level from keyboard stage; may change at any time relative to ck
key_valid  output  1  one-cycle pulse: a complete keypress was decoded
key_value  output  4  decoded key, valid with key_valid: 0-9 digits, 4'hA = '-', 4'hB = '*'
digits_bcd  output  16  current entry buffer, {H1,H0,M1,M0}, newest digit in [3:0]
digit_count  output  3  digits held, 0..4
load_time  output  1  one-cycle pulse; time_bcd valid
load_alarm  output  1  one-cycle pulse; time_bcd valid
time_bcd  output  16  entry captured at command; holds until the next command
entry_error  output  1  one-cycle pulse: command rejected
entry_timeout  output  1  one-cycle pulse: entry discarded by timeout

Behaviour:
- Key codes come from the keycodes.vh macros (KP_0..KP_9, KP_MINUS, KP_STAR, KP_KEY_RELEASED, KP_INVALID). A "valid key" is any of the 12 keypad codes.
- Input stage: `code_q <= ps2_key_code; prev_q <= code_q` each edge. `new_code = (code_q != prev_q)`. Only `new_code` events drive the FSM, so a held level is one event. Two identical consecutive presses must be separated by a different code (e.g. KP_INVALID).
- FSM (state, plus `key_reg[7:0]`), evaluated only when `new_code`:
  - IDLE: valid key -> MAKE, `key_reg <= code_q`. Anything else -> stay.
  - MAKE: KP_KEY_RELEASED -> BREAK. A different valid key -> MAKE, `key_reg` replaced (rollover). Other codes -> stay.
  - BREAK: `code_q == key_reg` -> emit event, go to IDLE. A different valid key -> MAKE with the new key (abort old press). KP_INVALID/other -> stay.
- Event emission is registered on the edge that processes the final make code:
  - `key_valid`/`key_value` are high for exactly one cycle.
  - Latency: input change -> `key_valid` high after the 2nd posedge.
- Digit event: `digits_bcd <= {digits_bcd[11:0], d}`; `digit_count` increments, saturating at 4. A 5th+ digit still shifts, so the buffer keeps the last four.
- '-' or '*' event, on the same edge as `key_valid`:
  - Accept only if `digit_count == 4`, hours <= 8'h23, minutes <= 8'h59, and all nibbles <= 9. On accept: `time_bcd <= digits_bcd`, and pulse `load_time` ('-') or `load_alarm` ('*').
  - Otherwise pulse `entry_error`; `time_bcd` is unchanged.
  - Either way, `digits_bcd <= 0` and `digit_count <= 0`.
- Timeout:
  - 32-bit `idle_cnt` counts while `digit_count != 0` or FSM != IDLE. It clears on any `new_code` and holds at 0 when idle and empty.
  - When `idle_cnt == TIMEOUT_CYCLES-1`: clear the buffer, FSM -> IDLE, pulse `entry_timeout`, `idle_cnt <= 0`.
  - If a `new_code` arrives on that same edge, `new_code` wins and there is no timeout.
- Simultaneous events: at most one key event per cycle by construction. Strobes are mutually exclusive.
- Reset (any cycle, including mid-sequence or mid-pulse):
  - `code_q`, `prev_q`, `key_reg` = 8'h00.
  - FSM = IDLE; `idle_cnt` = 0.
  - All outputs = 0, including `time_bcd` = 16'h0000, `digits_bcd` = 0, and `digit_count` = 0.
  - A nonzero code present at reset deassertion counts as one `new_code`.
- Strobes are never asserted during reset.

Test Plan:
- Sequences 1/F0/1, INVALID, 2/F0/2, INVALID, 3/F0/3, INVALID, 4/F0/4, INVALID, then '-'/F0/'-' -> four `key_valid` pulses (values 1,2,3,4), then `load_time` for 1 cycle with `time_bcd` = 16'h1234, `digit_count` = 0.
- Same flow with digits 1,2,3,5 and '*' -> `load_alarm` 1 cycle, `time_bcd` = 16'h1235; `load_time` stays 0.
- Digits 2,5,0,0 then '-' -> `entry_error` 1 cycle, no `load_time`, `time_bcd` unchanged. Digits 1,2 then '*' -> `entry_error`, `digit_count` = 0.
- 9/F0/9 then INVALID held for TIMEOUT_CYCLES (set to 20) -> `entry_timeout` exactly TIMEOUT_CYCLES cycles after the last code change, `digit_count` 1 -> 0. A code change at cycle 19 suppresses the timeout.
- Codes 1, F0, 2, F0, 2 -> exactly one `key_valid` with `key_value` = 2. Code 1 held 50 cycles -> no event. 1/F0/1 followed by 1 without a separator -> one event only.
- Enter 1,2,3; assert `reset` during the F0 of a 4th key -> all outputs 0. After release, 4/F0/4 -> `digit_count` = 1, `digits_bcd` = 16'h0004.
